// File: rtl/branch_resolve_unit.sv
// Branch resolution for the execute stage: operand bypass select, RV32I branch
// compare/decode, mispredict detection, optional one-entry output slot and mispredict counter.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_BYP = 2,
  parameter int PIPE    = 1,
  parameter int CNT_W   = 16,
  parameter int SEL_W   = $clog2(NUM_BYP + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_funct3,
  input  logic                    in_pred_taken,
  input  logic [XLEN-1:0]         rs1,
  input  logic [XLEN-1:0]         rs2,
  input  logic [NUM_BYP*XLEN-1:0] byp_data,
  input  logic [SEL_W-1:0]        byp_sel_rs1,
  input  logic [SEL_W-1:0]        byp_sel_rs2,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_taken,
  output logic                    out_eq,
  output logic                    out_lt,
  output logic                    out_mispredict,
  output logic                    out_illegal,
  output logic [CNT_W-1:0]        mispred_count
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            res_eq;
  logic            res_lt;
  logic            res_taken;
  logic            res_illegal;
  logic            res_mispredict;
  logic            cnt_inc;

  // Select 0, and any value above NUM_BYP, keeps the register-file operand.
  always_comb begin
    op_a = rs1;
    op_b = rs2;
    for (int k = 0; k < NUM_BYP; k++) begin
      if (byp_sel_rs1 == SEL_W'(k + 1)) op_a = byp_data[k*XLEN +: XLEN];
      if (byp_sel_rs2 == SEL_W'(k + 1)) op_b = byp_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    res_eq = (op_a == op_b);
    if (in_funct3[1]) res_lt = (op_a < op_b);
    else              res_lt = ($signed(op_a) < $signed(op_b));
  end

  always_comb begin
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (in_funct3)
      3'b000:         res_taken = res_eq;
      3'b001:         res_taken = ~res_eq;
      3'b100, 3'b110: res_taken = res_lt;
      3'b101, 3'b111: res_taken = ~res_lt;
      default:        res_illegal = 1'b1;
    endcase
    res_mispredict = res_illegal ? 1'b0 : (res_taken ^ in_pred_taken);
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a producer holds its payload stable until the transfer.
  generate
    if (PIPE != 0) begin : g_slot
      logic slot_valid;
      logic slot_taken;
      logic slot_eq;
      logic slot_lt;
      logic slot_mispredict;
      logic slot_illegal;

      assign in_ready = rst_n & (~slot_valid | out_ready);

      // flush wins over both capture and drain; a request accepted alongside it is dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid      <= 1'b0;
          slot_taken      <= 1'b0;
          slot_eq         <= 1'b0;
          slot_lt         <= 1'b0;
          slot_mispredict <= 1'b0;
          slot_illegal    <= 1'b0;
        end else if (flush) begin
          slot_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
          slot_valid      <= 1'b1;
          slot_taken      <= res_taken;
          slot_eq         <= res_eq;
          slot_lt         <= res_lt;
          slot_mispredict <= res_mispredict;
          slot_illegal    <= res_illegal;
        end else if (out_ready) begin
          slot_valid <= 1'b0;
        end
      end

      assign out_valid      = slot_valid;
      assign out_taken      = slot_taken;
      assign out_eq         = slot_eq;
      assign out_lt         = slot_lt;
      assign out_mispredict = slot_mispredict;
      assign out_illegal    = slot_illegal;
    end else begin : g_pass
      assign in_ready       = out_ready & rst_n;
      assign out_valid      = in_valid;
      assign out_taken      = res_taken;
      assign out_eq         = res_eq;
      assign out_lt         = res_lt;
      assign out_mispredict = res_mispredict;
      assign out_illegal    = res_illegal;
    end
  endgenerate

  assign cnt_inc = out_valid & out_ready & out_mispredict & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_count <= '0;
    end else if (cnt_inc && (mispred_count != {CNT_W{1'b1}})) begin
      mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the execute stage of the pipelined core. Selects each operand from the register file or one of NUM_BYP bypass sources, evaluates all six RV32I branch conditions from funct3, and compares the outcome with the fetch-stage prediction. The result is held in an optional output register with a valid/ready handshake. A saturating mispredict counter is included for performance monitoring.

## Interface
- XLEN, 32: operand width in bits, from 8 to 64.
- NUM_BYP, 2: number of bypass sources, from 1 to 7.
- PIPE, 1: 1 selects a registered output slot; 0 selects a combinational pass-through.
- CNT_W, 16: width of the mispredict counter.
- SEL_W: derived parameter, equal to $clog2(NUM_BYP+1).

Ports:
- clk  in  1  clock. Only rising edges are used.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle.
- in_funct3  in  3  branch funct3.
- in_pred_taken  in  1  predicted direction.
- rs1, rs2  in  XLEN  register-file operands.
- byp_data  in  NUM_BYP*XLEN  bypass values; source k occupies bits [k*XLEN +: XLEN].
- byp_sel_rs1, byp_sel_rs2  in  SEL_W  operand select. 0 selects the register file; k in 1..NUM_BYP selects source k-1.
- flush  in  1  synchronous kill of the held result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken, out_eq, out_lt, out_mispredict, out_illegal  out  1 each  result fields.
- mispred_count  out  CNT_W  saturating count of mispredicts.

## Operation
- Operand mux:
  - A select value greater than NUM_BYP falls back to the register file.
  - The rs1 and rs2 selects are independent and may pick the same source.
- Compare:
  - eq = (a == b).
  - lt = unsigned a < b when funct3[1] is 1, otherwise signed a < b.
  - When eq is 1, lt is 0.
- Decode of funct3:
  - 000: taken = eq.
  - 001: taken = !eq.
  - 100 and 110: taken = lt.
  - 101 and 111: taken = !lt.
  - 010 and 011: illegal = 1 and taken = 0.
- mispredict = taken XOR in_pred_taken. It is forced to 0 when illegal is 1.
- PIPE=1 (one-entry slot):
  - in_ready = rst_n AND (!out_valid OR out_ready).
  - When in_valid and in_ready are both 1, the result fields are captured and out_valid is set to 1 on the next edge.
  - When out_valid and out_ready are both 1 and no new request is accepted, out_valid clears.
  - Accept and drain in the same cycle gives a back-to-back result with no bubble.
  - Held result fields stay stable while out_valid=1 and out_ready=0.
- PIPE=0 (pass-through):
  - out_valid = in_valid and in_ready = out_ready & rst_n.
  - Result fields follow the inputs combinationally.
- flush (PIPE=1):
  - out_valid clears on the next edge.
  - Any request accepted in the same cycle is discarded.
  - flush has priority over both accept and drain.
- flush (PIPE=0): no effect on the data path.
- Counter:
  - Increments on each completed output handshake (out_valid & out_ready) with out_mispredict = 1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - No increment in a cycle where flush is 1.
- Reset (asynchronous):
  - out_valid, all result fields and mispred_count go to 0.
  - in_ready is held at 0 while rst_n is low.

## Timing
- PIPE=1: one cycle from accept to out_valid. Throughput is one result per cycle while out_ready is held at 1.
- PIPE=0: zero-cycle latency. The output is combinational from inputs.
- mispred_count updates on the edge that completes the counted handshake. The new value is visible in the following cycle.
- Reset deasserted mid-operation: the first accept can occur in the first cycle with rst_n=1. A result held before reset is lost.

## Test plan
- XLEN=32, PIPE=1, funct3=100, rs1=0xFFFFFFFF, rs2=1, sel=0 -> next cycle out_valid=1, out_lt=1, out_taken=1. Repeat with funct3=110 -> out_lt=0, out_taken=0.
- byp_sel_rs1=2 (byp source 1 = 5), byp_sel_rs2=1 (source 0 = 5), funct3=001, pred_taken=1 -> out_eq=1, out_taken=0, out_mispredict=1; mispred_count goes 0 -> 1 after the handshake. Also drive sel=NUM_BYP+1 -> the operand comes from rs1/rs2.
- Backpressure: accept A, hold out_ready=0 for 3 cycles -> in_ready=0 and A's fields stable. Then out_ready=1 with B presented -> A drains and B appears the next cycle with no bubble.
- flush together with an accept of C while A is held -> next cycle out_valid=0, C is dropped and mispred_count is unchanged.
- CNT_W=2 with 5 consecutive mispredicts -> mispred_count reads 1, 2, 3, 3, 3. funct3=011 -> out_illegal=1, out_taken=0, no count.
- Assert rst_n=0 asynchronously while out_valid=1 -> out_valid, result fields and count go to 0 immediately and in_ready=0. After release, an accept in the first cycle produces its result one cycle later.
